// File: rtl/eeg_pad_deser_if.sv
// Pad-side beat stream and word-side stream bundle for eeg_pad_deser.
// master drives pad beats / consumes words; slave is the deserializer.
interface eeg_pad_deser_if #(
  parameter int PAD_DW     = 8,
  parameter int WORD_DW    = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int RATIO = WORD_DW / PAD_DW;
  localparam int NB_W  = $clog2(RATIO + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic               pad_vld;
  logic               pad_lst;
  logic               pad_cmd;
  logic [PAD_DW-1:0]  pad_dat;
  logic               pad_rdy;
  logic               word_vld;
  logic               word_rdy;
  logic [WORD_DW-1:0] word_dat;
  logic [NB_W-1:0]    word_nbeat;
  logic               word_cmd;
  logic               word_lst;
  logic [LVL_W-1:0]   fifo_lvl;

  modport master (
    output pad_vld, pad_lst, pad_cmd, pad_dat, word_rdy,
    input  pad_rdy, word_vld, word_dat, word_nbeat,
    input  word_cmd, word_lst, fifo_lvl
  );

  modport slave (
    input  pad_vld, pad_lst, pad_cmd, pad_dat, word_rdy,
    output pad_rdy, word_vld, word_dat, word_nbeat,
    output word_cmd, word_lst, fifo_lvl
  );
endinterface

// File: rtl/eeg_pad_deser.sv
// Pad beat deserializer: packs PAD_DW beats into WORD_DW words, splits
// on frame end or cmd/data change, buffers words in a fall-through FIFO.
// Ports: clk, rst (sync, active-high), bus (slave modport: pad_* in,
// pad_rdy out, word_* out, word_rdy in, fifo_lvl out).
module eeg_pad_deser #(
  parameter int PAD_DW     = 8,
  parameter int WORD_DW    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  eeg_pad_deser_if.slave bus
);
  localparam int RATIO = WORD_DW / PAD_DW;
  localparam int NB_W  = $clog2(RATIO + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam bit MULTI = (RATIO > 1);

  logic [NB_W-1:0]    r_cnt;
  logic               r_cmd;
  logic [WORD_DW-1:0] r_dat;

  logic [WORD_DW-1:0] r_mem_dat [FIFO_DEPTH];
  logic [NB_W-1:0]    r_mem_nb  [FIFO_DEPTH];
  logic               r_mem_cmd [FIFO_DEPTH];
  logic               r_mem_lst [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [LVL_W-1:0]   r_lvl;

  logic               w_full;
  logic               w_empty;
  logic               w_cmd_chg;
  logic               w_acc;
  logic               w_end;
  logic               w_flush;
  logic               w_push;
  logic               w_pop;
  logic [WORD_DW-1:0] w_ins;
  logic [WORD_DW-1:0] w_in_dat;
  logic [NB_W-1:0]    w_in_nb;
  logic               w_in_cmd;
  logic               w_in_lst;

  assign w_full  = (r_lvl == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_lvl == '0);

  // A beat of the other kind may not join a partial word; it is
  // held off one cycle while the partial word is flushed.
  assign w_cmd_chg = MULTI && (r_cnt != '0) && bus.pad_vld
                     && (bus.pad_cmd != r_cmd);

  assign bus.pad_rdy = !rst && !w_full && !w_cmd_chg;

  assign w_acc   = bus.pad_vld && bus.pad_rdy;
  assign w_end   = (r_cnt == NB_W'(RATIO - 1)) || bus.pad_lst;
  assign w_flush = !rst && w_cmd_chg && !w_full;
  assign w_push  = (w_acc && w_end) || w_flush;
  assign w_pop   = !rst && bus.word_rdy && !w_empty;

  // Little-endian placement: beat k lands at bits [k*PAD_DW +: PAD_DW].
  assign w_ins = r_dat
               | (WORD_DW'(bus.pad_dat) << (PAD_DW * int'(r_cnt)));

  always_comb begin
    w_in_dat = w_ins;
    w_in_nb  = r_cnt + NB_W'(1);
    w_in_cmd = (r_cnt == '0) ? bus.pad_cmd : r_cmd;
    w_in_lst = bus.pad_lst;
    if (w_flush) begin
      w_in_dat = r_dat;
      w_in_nb  = r_cnt;
      w_in_cmd = r_cmd;
      w_in_lst = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_cmd <= 1'b0;
      r_dat <= '0;
    end else if (w_flush) begin
      r_cnt <= '0;
      r_dat <= '0;
    end else if (w_acc) begin
      if (r_cnt == '0) r_cmd <= bus.pad_cmd;
      if (w_end) begin
        r_cnt <= '0;
        r_dat <= '0;
      end else begin
        r_cnt <= r_cnt + NB_W'(1);
        r_dat <= w_ins;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dat[r_wptr] <= w_in_dat;
      r_mem_nb[r_wptr]  <= w_in_nb;
      r_mem_cmd[r_wptr] <= w_in_cmd;
      r_mem_lst[r_wptr] <= w_in_lst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_lvl  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_lvl <= r_lvl + LVL_W'(1);
        2'b01:   r_lvl <= r_lvl - LVL_W'(1);
        default: r_lvl <= r_lvl;
      endcase
    end
  end

  assign bus.word_vld   = !rst && !w_empty;
  assign bus.word_dat   = rst ? '0   : r_mem_dat[r_rptr];
  assign bus.word_nbeat = rst ? '0   : r_mem_nb[r_rptr];
  assign bus.word_cmd   = rst ? 1'b0 : r_mem_cmd[r_rptr];
  assign bus.word_lst   = rst ? 1'b0 : r_mem_lst[r_rptr];
  assign bus.fifo_lvl   = r_lvl;
endmodule

// File: tb/tb_eeg_pad_deser.sv
// Directed bench for eeg_pad_deser: default 8->32 build with depth 4,
// plus a 16->16 build with depth 8.
module tb_eeg_pad_deser;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  eeg_pad_deser_if #(.PAD_DW(8), .WORD_DW(32), .FIFO_DEPTH(4)) a_if ();
  eeg_pad_deser_if #(.PAD_DW(16), .WORD_DW(16), .FIFO_DEPTH(8)) b_if ();

  eeg_pad_deser #(.PAD_DW(8), .WORD_DW(32), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .bus(a_if)
  );
  eeg_pad_deser #(.PAD_DW(16), .WORD_DW(16), .FIFO_DEPTH(8)) u_b (
    .clk(clk), .rst(rst), .bus(b_if)
  );

  typedef struct {
    logic        vld;
    logic        lst;
    logic        cmd;
    logic [7:0]  dat;
    logic        rdy;
    logic        prdy;
    logic        wvld;
    logic [31:0] wdat;
    int          nb;
    logic        wcmd;
    logic        wlst;
    int          lvl;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, nxt, npop, stop;
    logic [31:0] ew;

    tv[0]  = '{0,0,0,8'h00,1, 1,0,32'h0,0,0,0,0};
    tv[1]  = '{1,0,0,8'h11,1, 1,0,32'h0,0,0,0,0};
    tv[2]  = '{1,0,0,8'h22,1, 1,0,32'h0,0,0,0,0};
    tv[3]  = '{1,0,0,8'h33,1, 1,0,32'h0,0,0,0,0};
    tv[4]  = '{1,1,0,8'h44,1, 1,0,32'h0,0,0,0,0};
    tv[5]  = '{1,0,0,8'hAA,1, 1,1,32'h44332211,4,0,1,1};
    tv[6]  = '{1,1,0,8'hBB,1, 1,0,32'h0,0,0,0,0};
    tv[7]  = '{1,0,1,8'h05,1, 1,1,32'h0000BBAA,2,0,1,1};
    tv[8]  = '{1,0,0,8'h10,1, 0,0,32'h0,0,0,0,0};
    tv[9]  = '{1,0,0,8'h10,1, 1,1,32'h00000005,1,1,0,1};
    tv[10] = '{1,1,0,8'h20,1, 1,0,32'h0,0,0,0,0};
    tv[11] = '{0,0,0,8'h00,1, 1,1,32'h00002010,2,0,1,1};
    tv[12] = '{1,1,1,8'hC1,1, 1,0,32'h0,0,0,0,0};
    tv[13] = '{0,0,0,8'h00,1, 1,1,32'h000000C1,1,1,1,1};
    tv[14] = '{0,0,0,8'h00,1, 1,0,32'h0,0,0,0,0};

    rst = 1'b1;
    a_if.pad_vld = 0; a_if.pad_lst = 0; a_if.pad_cmd = 0;
    a_if.pad_dat = '0; a_if.word_rdy = 0;
    b_if.pad_vld = 0; b_if.pad_lst = 0; b_if.pad_cmd = 0;
    b_if.pad_dat = '0; b_if.word_rdy = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_prdy", a_if.pad_rdy, 0);
    chk("rst_wvld", a_if.word_vld, 0);
    chk("rst_wdat", a_if.word_dat, 0);
    chk("rst_nb", a_if.word_nbeat, 0);
    chk("rst_cmd", a_if.word_cmd, 0);
    chk("rst_lst", a_if.word_lst, 0);
    chk("rst_lvl", a_if.fifo_lvl, 0);
    chk("rst_b_prdy", b_if.pad_rdy, 0);
    nxt_cyc();
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      a_if.pad_vld  = tv[i].vld;
      a_if.pad_lst  = tv[i].lst;
      a_if.pad_cmd  = tv[i].cmd;
      a_if.pad_dat  = tv[i].dat;
      a_if.word_rdy = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_prdy", i), a_if.pad_rdy, tv[i].prdy);
      chk($sformatf("v%0d_wvld", i), a_if.word_vld, tv[i].wvld);
      chk($sformatf("v%0d_lvl", i), a_if.fifo_lvl, tv[i].lvl);
      if (tv[i].wvld) begin
        chk($sformatf("v%0d_wdat", i), a_if.word_dat, tv[i].wdat);
        chk($sformatf("v%0d_nb", i), a_if.word_nbeat, tv[i].nb);
        chk($sformatf("v%0d_cmd", i), a_if.word_cmd, tv[i].wcmd);
        chk($sformatf("v%0d_lst", i), a_if.word_lst, tv[i].wlst);
      end
      nxt_cyc();
    end

    // backpressure: 20 data beats into a stalled consumer
    a_if.word_rdy = 0; a_if.pad_lst = 0; a_if.pad_cmd = 0;
    nxt = 1; acc = 0; stop = 0;
    for (int c = 0; c < 40 && stop == 0; c++) begin
      a_if.pad_vld = 1;
      a_if.pad_dat = 8'(nxt);
      @(negedge clk);
      if (a_if.pad_rdy) begin
        nxt++; acc++;
        nxt_cyc();
      end else begin
        stop = 1;
      end
    end
    chk("bp_accepted", acc, 16);
    chk("bp_lvl", a_if.fifo_lvl, 4);
    chk("bp_prdy_low", a_if.pad_rdy, 0);
    nxt_cyc();
    @(negedge clk);
    chk("bp_hold_dat", a_if.word_dat, 32'h04030201);
    chk("bp_hold_vld", a_if.word_vld, 1);
    nxt_cyc();
    a_if.word_rdy = 1;
    @(negedge clk);
    chk("bp_first_pop_prdy", a_if.pad_rdy, 0);
    npop = 0;
    if (a_if.word_vld) begin
      chk("bp_w0_dat", a_if.word_dat, 32'h04030201);
      npop = 1;
    end
    nxt_cyc();
    for (int c = 0; c < 60 && npop < 5; c++) begin
      a_if.pad_vld = (nxt <= 20);
      a_if.pad_dat = 8'(nxt);
      @(negedge clk);
      if (c == 0) chk("bp_prdy_back", a_if.pad_rdy, 1);
      if (a_if.pad_vld && a_if.pad_rdy) nxt++;
      if (a_if.word_vld) begin
        ew = '0;
        for (int b = 0; b < 4; b++)
          ew = ew | (32'(4*npop + b + 1) << (8*b));
        chk($sformatf("bp_w%0d_dat", npop), a_if.word_dat, ew);
        chk($sformatf("bp_w%0d_nb", npop), a_if.word_nbeat, 4);
        chk($sformatf("bp_w%0d_lst", npop), a_if.word_lst, 0);
        npop++;
      end
      nxt_cyc();
    end
    a_if.pad_vld = 0;
    chk("bp_pops", npop, 5);
    chk("bp_beats", nxt, 21);
    @(negedge clk);
    chk("bp_empty", a_if.fifo_lvl, 0);
    nxt_cyc();

    // reset with 3 words queued and 2 beats held
    a_if.word_rdy = 0;
    for (int i = 0; i < 14; i++) begin
      a_if.pad_vld = 1;
      a_if.pad_dat = 8'(8'h30 + i);
      nxt_cyc();
    end
    a_if.pad_vld = 0;
    @(negedge clk);
    chk("mr_lvl_pre", a_if.fifo_lvl, 3);
    nxt_cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_rst_prdy", a_if.pad_rdy, 0);
    chk("mr_rst_wvld", a_if.word_vld, 0);
    chk("mr_rst_wdat", a_if.word_dat, 0);
    nxt_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_lvl", a_if.fifo_lvl, 0);
    chk("mr_wvld", a_if.word_vld, 0);
    chk("mr_prdy", a_if.pad_rdy, 1);
    nxt_cyc();
    a_if.word_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      a_if.pad_vld = 1;
      a_if.pad_dat = 8'(8'hA1 + i);
      a_if.pad_lst = (i == 3);
      nxt_cyc();
    end
    a_if.pad_vld = 0; a_if.pad_lst = 0;
    npop = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_if.word_vld) begin
        chk("mr_w_dat", a_if.word_dat, 32'hA4A3A2A1);
        chk("mr_w_nb", a_if.word_nbeat, 4);
        chk("mr_w_lst", a_if.word_lst, 1);
        npop++;
      end
      nxt_cyc();
    end
    chk("mr_pops", npop, 1);

    // RATIO=1, depth 8: alternating cmd flag, no bubbles
    b_if.word_rdy = 0;
    nxt = 0; acc = 0; stop = 0;
    for (int c = 0; c < 30 && stop == 0; c++) begin
      b_if.pad_vld = 1;
      b_if.pad_dat = 16'(16'h1000 + nxt);
      b_if.pad_cmd = nxt[0];
      @(negedge clk);
      if (b_if.pad_rdy) begin
        nxt++; acc++;
        nxt_cyc();
      end else begin
        stop = 1;
      end
    end
    chk("r1_accepted", acc, 8);
    chk("r1_lvl", b_if.fifo_lvl, 8);
    nxt_cyc();
    b_if.word_rdy = 1;
    npop = 0;
    for (int c = 0; c < 60 && npop < 10; c++) begin
      b_if.pad_vld = (nxt < 10);
      b_if.pad_dat = 16'(16'h1000 + nxt);
      b_if.pad_cmd = nxt[0];
      @(negedge clk);
      if (b_if.pad_vld && b_if.pad_rdy) nxt++;
      if (b_if.word_vld) begin
        chk($sformatf("r1_w%0d_dat", npop), b_if.word_dat,
            16'(16'h1000 + npop));
        chk($sformatf("r1_w%0d_nb", npop), b_if.word_nbeat, 1);
        chk($sformatf("r1_w%0d_cmd", npop), b_if.word_cmd, npop % 2);
        npop++;
      end
      nxt_cyc();
    end
    b_if.pad_vld = 0;
    chk("r1_pops", npop, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eeg_pad_deser.md
# eeg_pad_deser

Parametrised pad-side input deserializer for the EEG chip. It accepts narrow valid/last/ready beats with a command flag from the chip data pads (the CHIP_DAT_* group). It packs them into wide words, splits word boundaries on frame end or command/data change, and buffers the words in a small FIFO. The words are presented on a valid/ready stream to the internal command decoder and data path.

## Interface
- PAD_DW, 8, pad data width per beat
- WORD_DW, 32, output word width; must be an integer multiple of PAD_DW; RATIO = WORD_DW/PAD_DW (≥1)
- FIFO_DEPTH, 4, word FIFO depth; power of two, ≥2
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- pad_vld  in  1  beat valid
- pad_lst  in  1  beat is last of frame
- pad_cmd  in  1  beat is command (1) or data (0)
- pad_dat  in  PAD_DW  beat payload
- pad_rdy  out  1  beat accepted when pad_vld & pad_rdy
- word_vld  out  1  word available
- word_rdy  in  1  consumer accepts word when word_vld & word_rdy
- word_dat  out  WORD_DW  packed word, zero-padded above valid beats
- word_nbeat  out  clog2(RATIO+1)  number of valid beats in word (1..RATIO)
- word_cmd  out  1  command flag of every beat in the word
- word_lst  out  1  word ends a frame
- fifo_lvl  out  clog2(FIFO_DEPTH+1)  words currently stored

## Operation
- Assembler state: asm_cnt (0..RATIO-1 beats held), asm_cmd, asm_dat shift register.
- Packing little-endian: beat k of a word occupies bits [k*PAD_DW +: PAD_DW]; the first beat goes in the LSBs.
- First beat of a word (asm_cnt==0) latches asm_cmd = pad_cmd.
- Word completes on an accepted beat when asm_cnt+1 == RATIO or pad_lst==1. The word is pushed to the FIFO with nbeat = asm_cnt+1, lst = pad_lst, and cmd = asm_cmd (or pad_cmd if the beat is the first of the word). asm_cnt returns to 0.
- Command change: if asm_cnt!=0 and pad_vld and pad_cmd != asm_cmd, the beat is NOT accepted that cycle (pad_rdy=0).
  - The held partial word is pushed with nbeat=asm_cnt and lst=0; asm_cnt goes to 0.
  - The beat is accepted on a following cycle as the first beat of a new word.
- pad_rdy = !rst & !fifo_full & !cmd_change. pad_rdy depends combinationally on pad_vld and pad_cmd only through the cmd_change term.
- A flush caused by a command change also requires !fifo_full; if the FIFO is full, the flush waits.
- At most one push per cycle, by construction.
- FIFO: fall-through. word_vld = (fifo_lvl != 0); word_* show the head entry.
  - Push and pop in the same cycle are allowed when not full; fifo_lvl is unchanged.
  - When full, no push occurs even if a pop happens the same cycle, because pad_rdy was already low.
- RATIO==1: every accepted beat completes a word, no partial word is ever held, and cmd_change never asserts.

## Timing
- Reset (rst high at a clk edge): asm_cnt=0, asm_cmd=0, asm_dat=0, FIFO pointers 0, fifo_lvl=0.
  - While rst is high: pad_rdy=0, word_vld=0, word_dat=0, word_nbeat=0, word_cmd=0, word_lst=0.
- First cycle after rst deasserts: pad_rdy=1 (given pad_vld=0 or no cmd change), word_vld=0.
- Reset mid-word or with a full FIFO discards all held beats and words. Nothing is emitted afterwards.
- Latency: a word-completing beat accepted at edge N gives word_vld=1 in the cycle following N (1 cycle). A cmd-change flush has the same latency from the flush edge.
- Sustained throughput: one beat per cycle; one word per RATIO cycles. Throughput stalls only on a full FIFO or a one-cycle cmd-change bubble.
- word_* outputs hold stable while word_vld=1 and word_rdy=0.
- Wrap-around: read/write pointers are clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from fifo_lvl.
- Backpressure: with word_rdy=0, fifo_lvl reaches FIFO_DEPTH and pad_rdy drops in that same cycle. pad_rdy returns to 1 the cycle after the first pop.

## Test plan
- Defaults throughout: PAD_DW=8, WORD_DW=32.
- Full word: send data beats 0x11,0x22,0x33,0x44 (lst on 0x44, cmd=0), word_rdy=1 -> one cycle later word_dat=0x44332211, nbeat=4, lst=1, cmd=0.
- Short frame: send beats 0xAA,0xBB with lst on 0xBB -> word_dat=0x0000BBAA, nbeat=2, lst=1.
- Cmd change: send cmd=1 beat 0x05, then a cmd=0 beat 0x10 on the next cycle -> pad_rdy=0 for one cycle.
  - Then word {0x00000005, nbeat=1, cmd=1, lst=0}.
  - Then 0x10 accepted as first beat of the next data word.
- Backpressure: word_rdy=0, stream 20 beats -> pad_rdy drops after 16 accepted beats, fifo_lvl=4.
  - Release word_rdy -> 4 words drain in order, remaining beats accepted, no loss or duplication.
- Reset mid-operation: assert rst with 2 beats held and 3 words queued -> next cycle fifo_lvl=0, word_vld=0.
  - A subsequent 4-beat frame produces exactly one correct word.
- Parameter sweep: PAD_DW=16/WORD_DW=16 (RATIO=1) and FIFO_DEPTH=8 -> every beat is one word with nbeat=1, and full occurs at 8.
